// File: rtl/keccak_pkg.sv
// Shared constants for the Keccak message padder.
// Build option: define KECCAK_SHA3_PAD_EN to use the SHA-3 domain suffix (0x06) as the first pad byte.
package keccak_pkg;

    localparam int RATE_BITS       = 576;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = 18;

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] PAD_FIRST = 8'h06;
`else
    localparam logic [7:0] PAD_FIRST = 8'h01;
`endif

    localparam logic [7:0] PAD_LAST = 8'h80;

endpackage

// File: rtl/keccak_pad_word.sv
// Builds the first padding word: keeps the top byte_num bytes of the final word and appends PAD_FIRST.
// PAD_FIRST depends on KECCAK_SHA3_PAD_EN through keccak_pkg.
module keccak_pad_word
    import keccak_pkg::*;
(
    input  logic [WORD_BITS-1:0] in,
    input  logic [1:0]           byte_num,
    output logic [WORD_BITS-1:0] pad_word
);

    always_comb begin
        pad_word = '0;
        case (byte_num)
            2'd0: pad_word = {PAD_FIRST, 24'h0};
            2'd1: pad_word = {in[31:24], PAD_FIRST, 16'h0};
            2'd2: pad_word = {in[31:16], PAD_FIRST, 8'h0};
            2'd3: pad_word = {in[31:8], PAD_FIRST};
            default: pad_word = '0;
        endcase
    end

endmodule

// File: rtl/keccak_padder.sv
// Packs 32-bit message words into 576-bit rate blocks and appends Keccak multi-rate padding.
// Build option: KECCAK_SHA3_PAD_EN selects the SHA-3 first pad byte (see keccak_pkg).
module keccak_padder
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_BITS-1:0]  in,
    input  logic                  in_ready,
    input  logic                  is_last,
    input  logic [1:0]            byte_num,
    output logic                  buffer_full,
    output logic [RATE_BITS-1:0]  out,
    output logic                  out_ready,
    input  logic                  f_ack
);

    logic                          state_q, state_d;
    logic                          done_q, done_d;
    logic [WORDS_PER_BLOCK-1:0]    i_q, i_d;
    logic [RATE_BITS-1:0]          out_q, out_d;

    logic [WORD_BITS-1:0]          pad_word;
    logic [WORD_BITS-1:0]          v;
    logic                          accept;
    logic                          update;

    keccak_pad_word u_pad_word (
        .in       (in),
        .byte_num (byte_num),
        .pad_word (pad_word)
    );

    assign buffer_full = i_q[WORDS_PER_BLOCK-1];
    assign out_ready   = i_q[WORDS_PER_BLOCK-1];
    assign out         = out_q;

    assign accept = ~state_q & in_ready & ~buffer_full;
    assign update = (accept | (state_q & ~buffer_full)) & ~done_q;

    always_comb begin
        v = in;
        if (state_q) begin
            v = '0;
        end else if (is_last) begin
            v = pad_word;
        end
        // Once padding has started, the 18th word of the block carries the closing 0x80.
        if ((state_q | is_last) && i_q[WORDS_PER_BLOCK-2]) begin
            v[7:0] = v[7:0] | PAD_LAST;
        end
    end

    always_comb begin
        state_d = state_q | is_last;
        done_d  = done_q | (state_q & buffer_full);
        i_d     = i_q;
        out_d   = out_q;
        if (update) begin
            out_d = {out_q[RATE_BITS-WORD_BITS-1:0], v};
            i_d   = {i_q[WORDS_PER_BLOCK-2:0], 1'b1};
        end
        if (f_ack) begin
            i_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 1'b0;
            done_q  <= 1'b0;
            i_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            i_q     <= i_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder; expected pad byte follows KECCAK_SHA3_PAD_EN.
module tb_keccak_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  in = '0;
    logic         in_ready = 1'b0;
    logic         is_last = 1'b0;
    logic [1:0]   byte_num = '0;
    logic         buffer_full;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack = 1'b0;

    int total = 0;
    int bad   = 0;

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] EXP_PAD = 8'h06;
`else
    localparam logic [7:0] EXP_PAD = 8'h01;
`endif

    keccak_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out         (out),
        .out_ready   (out_ready),
        .f_ack       (f_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_ready = 1'b0;
        is_last = 1'b0;
        f_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one word for one edge; caller sits on a negedge.
    task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
        in = w;
        in_ready = 1'b1;
        is_last = last;
        byte_num = bn;
        @(negedge clk);
        in_ready = 1'b0;
        is_last = 1'b0;
        byte_num = 2'd0;
    endtask

    task automatic wait_full(output int cyc);
        cyc = 0;
        while (!out_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack_and_hold(input string tag, input logic [575:0] blk);
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        check({tag, "_ready_drop"}, 576'(out_ready), 576'(0));
        repeat (20) @(negedge clk);
        check({tag, "_ready_stays0"}, 576'(out_ready), 576'(0));
        check({tag, "_out_held"}, out, blk);
    endtask

    initial begin
        logic [575:0] e;
        int cyc;

        @(negedge clk);
        // Reset
        do_reset();
        check("rst_out", out, '0);
        check("rst_full", 576'(buffer_full), 576'(0));
        check("rst_ready", 576'(out_ready), 576'(0));
        $display("reset done");

        // Empty message
        send(32'h0, 1'b1, 2'd0);
        wait_full(cyc);
        check("empty_cycles", 576'(cyc + 1), 576'(18));
        e = '0;
        e[575:544] = {EXP_PAD, 24'h0};
        e[31:0] = 32'h00000080;
        check("empty_block", out, e);
        $display("empty message: out_ready after %0d cycles", cyc + 1);

        // "abc"
        do_reset();
        send(32'h61626300, 1'b1, 2'd3);
        wait_full(cyc);
        check("abc_ready", 576'(out_ready), 576'(1));
        e = '0;
        e[575:544] = {24'h616263, EXP_PAD};
        e[31:0] = 32'h00000080;
        check("abc_block", out, e);
        ack_and_hold("abc", e);
        $display("abc message done");

        // Two full words then a 1-byte tail
        do_reset();
        send(32'hDEADBEEF, 1'b0, 2'd0);
        send(32'h01234567, 1'b0, 2'd0);
        send(32'h11223344, 1'b1, 2'd1);
        wait_full(cyc);
        check("tail1_cycles", 576'(cyc + 3), 576'(18));
        e = '0;
        e[575:544] = 32'hDEADBEEF;
        e[543:512] = 32'h01234567;
        e[511:480] = {8'h11, EXP_PAD, 16'h0};
        e[31:0] = 32'h00000080;
        check("tail1_block", out, e);
        $display("three-word message done");

        // Backpressure with 19 full words
        do_reset();
        e = '0;
        for (int k = 1; k <= 18; k++) begin
            send(32'hA000_0000 + 32'(k), 1'b0, 2'd0);
            e[575 - 32*(k-1) -: 32] = 32'hA000_0000 + 32'(k);
        end
        check("bp_full", 576'(buffer_full), 576'(1));
        check("bp_block", out, e);
        in = 32'hA000_0013;
        in_ready = 1'b1;
        @(negedge clk);
        check("bp_held_full", 576'(buffer_full), 576'(1));
        check("bp_held_out", out, e);
        f_ack = 1'b1;
        @(negedge clk);
        f_ack = 1'b0;
        check("bp_full_drop", 576'(buffer_full), 576'(0));
        @(negedge clk);
        in_ready = 1'b0;
        check("bp_w19", 576'(out[31:0]), 576'(32'hA000_0013));
        check("bp_w18", 576'(out[63:32]), 576'(32'hA000_0012));
        check("bp_after_full", 576'(buffer_full), 576'(0));
        $display("backpressure done");

        // Pad byte lands in the 18th word
        do_reset();
        e = '0;
        for (int k = 1; k <= 17; k++) begin
            send(32'hB000_0000 + 32'(k), 1'b0, 2'd0);
            e[575 - 32*(k-1) -: 32] = 32'hB000_0000 + 32'(k);
        end
        send(32'hAABBCCDD, 1'b1, 2'd2);
        e[31:0] = {16'hAABB, EXP_PAD | 8'h00, 8'h80};
        check("last_slot_full", 576'(out_ready), 576'(1));
        check("last_slot_block", out, e);
        ack_and_hold("last_slot", e);
        $display("pad in last slot done");

        // Mid-block reset discards the partial block
        send(32'h12345678, 1'b0, 2'd0);
        do_reset();
        check("midrst_out", out, '0);
        check("midrst_full", 576'(buffer_full), 576'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
